// File: rtl/mem_access_unit.sv
// Load/store unit between execute and writeback: checks each request for size, alignment
// and range faults, drives the data memory for one ACCESS cycle, then holds the response.
module mem_access_unit #(
  parameter int MEM_BYTES = 1024,
  parameter int FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic [11:0]       dm_addr,
  output logic [31:0]       dm_wr_data,
  output logic              dm_we,
  output logic [2:0]        dm_size,
  input  logic [31:0]       dm_rd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_fault,
  output logic [1:0]        rsp_cause,
  output logic [FCNT_W-1:0] fault_count
);

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_SIZE  = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;
  localparam logic [1:0] CAUSE_RANGE = 2'b11;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state;
  logic       store_p0;
  logic       accept;
  logic [1:0] req_cause;
  logic       req_fault;

  // Byte count of a size code; 0 marks an unsupported code.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    logic [2:0] nb;
    case (size)
      MEM_B, MEM_BU: nb = 3'd1;
      MEM_H, MEM_HU: nb = 3'd2;
      MEM_W:         nb = 3'd4;
      default:       nb = 3'd0;
    endcase
    return nb;
  endfunction

  // Range check uses a 33-bit end address so accesses near 2^32 cannot wrap back into range.
  function automatic logic [1:0] fault_cause(input logic [2:0] size, input logic [31:0] addr);
    logic [2:0]  nb;
    logic [32:0] end_addr;
    logic [1:0]  cause;
    nb       = size_bytes(size);
    end_addr = {1'b0, addr} + {30'd0, nb};
    if (nb == 3'd0)
      cause = CAUSE_SIZE;
    else if ((nb == 3'd2 && addr[0]) || (nb == 3'd4 && addr[1:0] != 2'b00))
      cause = CAUSE_ALIGN;
    else if (end_addr > MEM_LIMIT)
      cause = CAUSE_RANGE;
    else
      cause = CAUSE_NONE;
    return cause;
  endfunction

  assign req_ready = (state == IDLE) || (state == RESP && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign req_cause = fault_cause(req_size, req_addr);
  assign req_fault = (req_cause != CAUSE_NONE);

  // Stage p0: request latched at acceptance; memory port and response registers follow it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      store_p0    <= 1'b0;
      dm_addr     <= '0;
      dm_wr_data  <= '0;
      dm_we       <= 1'b0;
      dm_size     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_rd      <= '0;
      rsp_fault   <= 1'b0;
      rsp_cause   <= CAUSE_NONE;
      fault_count <= '0;
    end else if (accept) begin
      store_p0  <= req_is_store;
      rsp_rd    <= req_rd;
      rsp_cause <= req_cause;
      rsp_fault <= req_fault;
      rsp_data  <= '0;
      if (req_fault) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        dm_we     <= 1'b0;
        if (fault_count != {FCNT_W{1'b1}})
          fault_count <= fault_count + FCNT_W'(1);
      end else begin
        state      <= ACCESS;
        rsp_valid  <= 1'b0;
        dm_addr    <= req_addr[11:0];
        dm_size    <= req_size;
        dm_wr_data <= req_wdata;
        dm_we      <= req_is_store;
      end
    end else begin
      case (state)
        ACCESS: begin
          dm_we     <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
          if (!store_p0)
            rsp_data <= dm_rd_data;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        IDLE:    ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array data memory on the dm_* port, and a reference model
// that predicts fault cause, load data and fault count from address/size arithmetic.
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int MEM_BYTES = 1024;
  localparam int FCNT_W    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_size = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [11:0] dm_addr;
  logic [31:0] dm_wr_data;
  logic        dm_we;
  logic [2:0]  dm_size;
  logic [31:0] dm_rd_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_fault;
  logic [1:0]  rsp_cause;
  logic [FCNT_W-1:0] fault_count;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .dm_addr(dm_addr), .dm_wr_data(dm_wr_data), .dm_we(dm_we), .dm_size(dm_size),
    .dm_rd_data(dm_rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_fault(rsp_fault), .rsp_cause(rsp_cause), .fault_count(fault_count)
  );

  function automatic logic [7:0] init_pat(input logic [11:0] i);
    logic [11:0] t;
    t = i * 12'd29 + 12'd7;
    return t[7:0] ^ t[11:4];
  endfunction

  function automatic int ref_bytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // Data memory environment: little-endian bytes, sign/zero extension chosen by dm_size.
  logic [7:0]  mem     [4096];
  logic        wr_mask [4096];
  logic [7:0]  rb      [4];
  logic [11:0] idx;

  always_comb begin
    idx = '0;
    for (int k = 0; k < 4; k++) begin
      idx   = dm_addr + 12'(k);
      rb[k] = wr_mask[idx] ? mem[idx] : init_pat(idx);
    end
    case (dm_size)
      3'd0:    dm_rd_data = {{24{rb[0][7]}}, rb[0]};
      3'd4:    dm_rd_data = {24'd0, rb[0]};
      3'd1:    dm_rd_data = {{16{rb[1][7]}}, rb[1], rb[0]};
      3'd5:    dm_rd_data = {16'd0, rb[1], rb[0]};
      3'd2:    dm_rd_data = {rb[3], rb[2], rb[1], rb[0]};
      default: dm_rd_data = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (dm_we) begin
      for (int k = 0; k < 4; k++) begin
        if (k < ref_bytes(dm_size)) begin
          mem[12'(dm_addr + 12'(k))]     <= dm_wr_data[8*k +: 8];
          wr_mask[12'(dm_addr + 12'(k))] <= 1'b1;
        end
      end
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [4096];
  int         ref_fcnt = 0;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic logic [1:0] ref_cause(input logic [2:0] sz, input logic [31:0] addr);
    int nb;
    longint unsigned last;
    nb = ref_bytes(sz);
    if (nb == 0) return 2'b01;
    if ((addr % nb) != 0) return 2'b10;
    last = longint'(addr) + longint'(nb);
    if (last > longint'(MEM_BYTES)) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] addr);
    int nb;
    logic [31:0] v;
    nb = ref_bytes(sz);
    v  = 32'd0;
    for (int i = 0; i < nb; i++)
      v = v | (32'(ref_mem[int'(addr[11:0]) + i]) << (8 * i));
    if ((sz == 3'd0 || sz == 3'd1) && v[8*nb-1])
      v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    for (int i = 0; i < ref_bytes(sz); i++)
      ref_mem[int'(addr[11:0]) + i] = wd[8*i +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete request with rsp_ready high; checks the ACCESS cycle and the response.
  task automatic run_req(input logic st, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, output logic [31:0] got);
    logic [1:0]  ec;
    logic [31:0] ed;
    int          waited;
    ec = ref_cause(sz, addr);
    ed = 32'd0;
    if (ec == 2'b00 && !st) ed = ref_load(sz, addr);
    if (ec == 2'b00 && st) ref_store(sz, addr, wd);
    if (ec != 2'b00 && ref_fcnt < 255) ref_fcnt++;
    @(negedge clk);
    rsp_ready    = 1'b1;
    req_valid    = 1'b1;
    req_is_store = st;
    req_size     = sz;
    req_addr     = addr;
    req_wdata    = wd;
    req_rd       = rd;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_size     = 3'($urandom);
    req_is_store = 1'($urandom);
    @(negedge clk);
    if (ec == 2'b00) begin
      check("access_rsp_valid", 32'(rsp_valid), 32'd0);
      check("access_dm_we", 32'(dm_we), 32'(st));
      check("access_dm_addr", 32'(dm_addr), 32'(addr[11:0]));
      check("access_dm_size", 32'(dm_size), 32'(sz));
      check("access_req_ready", 32'(req_ready), 32'd0);
      if (st) check("access_dm_wr_data", dm_wr_data, wd);
      @(negedge clk);
    end
    check("resp_dm_we", 32'(dm_we), 32'd0);
    check("resp_valid", 32'(rsp_valid), 32'd1);
    check("resp_data", rsp_data, ed);
    check("resp_rd", 32'(rsp_rd), 32'(rd));
    check("resp_fault", 32'(rsp_fault), 32'(ec != 2'b00));
    check("resp_cause", 32'(rsp_cause), 32'(ec));
    check("fault_count", 32'(fault_count), 32'(ref_fcnt));
    got = rsp_data;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, ed1, ed2, addr;
    logic [2:0]  sz;
    logic [2:0]  ill [3];
    int          cnt;
    ill[0] = 3'd3; ill[1] = 3'd6; ill[2] = 3'd7;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_pat(12'(i));

    // Reset state
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_rsp_cause", 32'(rsp_cause), 32'd0);
    check("rst_fault_count", 32'(fault_count), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_dm_addr", 32'(dm_addr), 32'd0);
    check("rst_dm_wr_data", dm_wr_data, 32'd0);
    check("rst_dm_size", 32'(dm_size), 32'd0);
    rst = 1'b1;

    // Word store then load
    run_req(1'b1, 3'd2, 32'h010, 32'hDEAD_BEEF, 5'd3, got);
    run_req(1'b0, 3'd2, 32'h010, 32'd0, 5'd7, got);
    check("word_load_value", got, 32'hDEAD_BEEF);

    // Signed and unsigned byte loads of 0x80
    run_req(1'b1, 3'd0, 32'h020, 32'h0000_0080, 5'd2, got);
    run_req(1'b0, 3'd0, 32'h020, 32'd0, 5'd4, got);
    check("lb_sign_ext", got, 32'hFFFF_FF80);
    run_req(1'b0, 3'd4, 32'h020, 32'd0, 5'd5, got);
    check("lbu_zero_ext", got, 32'h0000_0080);

    // Boundary addresses and fault priority
    run_req(1'b0, 3'd2, 32'h3FE, 32'd0, 5'd8, got);
    check("misaligned_cause", 32'(rsp_cause), 32'd2);
    run_req(1'b0, 3'd2, 32'h3FC, 32'd0, 5'd9, got);
    check("last_word_ok", 32'(rsp_fault), 32'd0);
    run_req(1'b0, 3'd2, 32'h400, 32'd0, 5'd10, got);
    check("out_of_range_cause", 32'(rsp_cause), 32'd3);
    run_req(1'b0, 3'd2, 32'hFFFF_FFFC, 32'd0, 5'd11, got);
    run_req(1'b1, 3'd7, 32'h401, 32'h1, 5'd12, got);
    run_req(1'b0, 3'd5, 32'h401, 32'd0, 5'd13, got);
    run_req(1'b1, 3'd1, 32'h3FF, 32'hABCD, 5'd14, got);
    run_req(1'b0, 3'd4, 32'h3FF, 32'd0, 5'd15, got);

    // Randomized requests
    for (int n = 0; n < 60; n++) begin
      case ($urandom % 4)
        0:       addr = $urandom;
        1:       addr = ($urandom % 256) * 4;
        default: addr = $urandom % 1024;
      endcase
      sz = 3'($urandom);
      run_req(1'($urandom), sz, addr, $urandom, 5'($urandom), got);
    end

    // Response stall, then accept a new request on the release cycle
    ed1 = ref_load(3'd2, 32'h3FC);
    ed2 = ref_load(3'd4, 32'h011);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 3'd2; req_addr = 32'h3FC; req_rd = 5'd9;
    @(posedge clk);
    #1;
    req_size = 3'd4; req_addr = 32'h011; req_rd = 5'd10;
    @(negedge clk);
    check("stall_access_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", rsp_data, ed1);
      check("stall_rd", 32'(rsp_rd), 32'd9);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("next_access_valid", 32'(rsp_valid), 32'd0);
    check("next_access_addr", 32'(dm_addr), 32'h011);
    @(negedge clk);
    check("next_resp_valid", 32'(rsp_valid), 32'd1);
    check("next_resp_data", rsp_data, ed2);
    check("next_resp_rd", 32'(rsp_rd), 32'd10);

    // Back-to-back throughput with rsp_ready held high
    ed1 = ref_load(3'd2, 32'h010);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 3'd2; req_addr = 32'h010; req_rd = 5'd5;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        cnt++;
        check("b2b_data", rsp_data, ed1);
      end
    end
    req_valid = 1'b0;
    check("b2b_resp_count", 32'(cnt), 32'd4);

    // Illegal size codes saturate the fault counter
    for (int n = 0; n < 256; n++) begin
      run_req(1'($urandom), ill[$urandom % 3], $urandom, $urandom, 5'($urandom), got);
    end
    check("fault_count_saturated", 32'(fault_count), 32'd255);

    // Reset during a store's ACCESS cycle
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 3'd2; req_addr = 32'h040;
    req_wdata = 32'h1234_5678; req_rd = 5'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    check("mid_access_dm_we", 32'(dm_we), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_dm_we", 32'(dm_we), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_dm_addr", 32'(dm_addr), 32'd0);
    check("arst_dm_wr_data", dm_wr_data, 32'd0);
    check("arst_dm_size", 32'(dm_size), 32'd0);
    check("arst_fault_count", 32'(fault_count), 32'd0);
    check("arst_rsp_rd", 32'(rsp_rd), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ref_fcnt = 0;
    run_req(1'b0, 3'd2, 32'h040, 32'd0, 5'd6, got);
    run_req(1'b0, 3'd7, 32'h040, 32'd0, 5'd6, got);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
